// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the CPU run controller.
// Optional feature macro used by cpu_run_ctrl: RUN_CTRL_AUTO_RESTART_EN.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        HALTED,
        TIMEOUT
    } run_state_t;

    // Default cycles cpu_rst is held per run (must be >= 1).
    localparam int RST_CYCLES_DEF = 2;
    // Default run-cycle budget (must be < 2**CNT_W).
    localparam int MAX_CYCLES_DEF = 30;
    // Default run-cycle counter width.
    localparam int CNT_W_DEF      = 8;

endpackage : run_ctrl_pkg

// File: rtl/run_cycle_counter.sv
// Run-cycle counter: sync clear, load-to-1 and count enable, with a
// compare flag that reports when the count has reached the budget.
module run_cycle_counter #(
    parameter int CNT_W      = 8,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             eq_max_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count register; clear beats load-1, which beats increment.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (load1_i) begin
            cnt_q <= CNT_W'(1);
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o    = cnt_q;
    assign eq_max_o = (cnt_q == CNT_W'(MAX_CYCLES));

endmodule : run_cycle_counter

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: generates the CPU reset pulse, counts run cycles,
// watches the CPU halt line and reports halt or timeout.
// Optional feature: define RUN_CTRL_AUTO_RESTART_EN to make HALTED and
// TIMEOUT last one cycle and fall straight back into RESET (free-running
// reset/run loop). Without it those states hold until start or rst.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hlt,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int               RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    run_state_t       state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             cnt_clr, cnt_load1, cnt_en, cnt_eq_max;
    logic             restart;
    logic             cpu_rst_q, running_q, done_q, timed_out_q;

    // Leaving HALTED/TIMEOUT: on request, or unconditionally in auto mode.
`ifdef RUN_CTRL_AUTO_RESTART_EN
    assign restart = 1'b1;
`else
    assign restart = start;
`endif

    run_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_counter (
        .clk      (clk),
        .rst_i    (rst),
        .clr_i    (cnt_clr),
        .load1_i  (cnt_load1),
        .en_i     (cnt_en),
        .cnt_o    (cycle_cnt),
        .eq_max_o (cnt_eq_max)
    );

    // Next-state and counter-control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves a signal unassigned (no latches).
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                    cnt_clr   = 1'b1;
                end
            end
            RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = RUN;
                    cnt_load1 = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            RUN: begin
                // A halt on the last budgeted cycle still counts as a halt.
                if (hlt) begin
                    state_d = HALTED;
                end else if (cnt_eq_max) begin
                    state_d = TIMEOUT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HALTED, TIMEOUT: begin
                if (restart) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                    cnt_clr   = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                rst_cnt_d = '0;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // State register; outputs are registered and decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            cpu_rst_q   <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            // TIMEOUT keeps the CPU in reset; HALTED leaves it observable.
            cpu_rst_q   <= (state_d == IDLE) || (state_d == RESET) || (state_d == TIMEOUT);
            running_q   <= (state_d == RUN);
            done_q      <= (state_d == HALTED) && (state_q != HALTED);
            timed_out_q <= (state_d == TIMEOUT);
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timed_out = timed_out_q;

endmodule : cpu_run_ctrl
